// File: rtl/reg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reg_pkg                                                       |
// | Brief    : Shared sizing and named register indices for the reg_file.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package reg_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

endpackage : reg_pkg
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reg_file                                                      |
// | Brief    : 2R1W register file, r0 hard-wired to zero, debug read port,   |
// |            committed-write counter. Define REG_FILE_BYPASS_EN for        |
// |            write-before-read forwarding on the rs/rt ports.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module reg_file
  import reg_pkg::*;
#(
  parameter int DATA_W = reg_pkg::DATA_W,
  parameter int ADDR_W = reg_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
);

  localparam int c_num_regs = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [c_num_regs];
  logic [15:0]       r_wr_count;
  logic              w_commit;

  assign w_commit = wr_en && (wr_addr != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_num_regs; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_count <= '0;
    end else if (w_commit) begin
      r_regs[wr_addr] <= wr_data;
      r_wr_count      <= r_wr_count + 16'd1;
    end
  end

  // r0 is masked on the read side, so its storage never needs to be written.
  function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] addr);
    return (addr == ADDR_W'(REG_ZERO)) ? '0 : r_regs[addr];
  endfunction

`ifdef REG_FILE_BYPASS_EN
  logic w_fwd;

  // Forwarding is held off during reset so the ports still read zero.
  always_comb begin
    w_fwd   = rst_n && w_commit;
    rs_data = (w_fwd && (rs_addr == wr_addr)) ? wr_data : f_read(rs_addr);
    rt_data = (w_fwd && (rt_addr == wr_addr)) ? wr_data : f_read(rt_addr);
  end
`else
  always_comb begin
    rs_data = f_read(rs_addr);
    rt_data = f_read(rt_addr);
  end
`endif

  always_comb begin
    dbg_data = f_read(dbg_addr);
  end

  assign wr_count = r_wr_count;

`ifndef SYNTHESIS
  a_wr_addr_known : assert property (@(posedge clk) disable iff (!rst_n)
    wr_en |-> !$isunknown(wr_addr));
`endif

endmodule : reg_file
`default_nettype wire

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter: DATA_W, default 32; register and data-port width.
REQ-002 Parameter: ADDR_W, default 5; register index width; NUM_REGS = 2**ADDR_W.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 rs_addr  in  ADDR_W  read-port A index (instruction rs field).
REQ-006 rt_addr  in  ADDR_W  read-port B index (instruction rt field).
REQ-007 rs_data  out  DATA_W  read-port A data; drives ALU operand a.
REQ-008 rt_data  out  DATA_W  read-port B data; drives ALU operand b or store data.
REQ-009 wr_en  in  1  write enable (RegWrite).
REQ-010 wr_addr  in  ADDR_W  write index (rd or rt after RegDst mux).
REQ-011 wr_data  in  DATA_W  write data (ALU result or load data after MemtoReg mux).
REQ-012 dbg_addr  in  ADDR_W  debug read index.
REQ-013 dbg_data  out  DATA_W  debug read data.
REQ-014 wr_count  out  16  count of committed writes to a non-zero register.

Function
REQ-015 Storage SHALL be NUM_REGS registers of DATA_W bits each.
REQ-016 Reads SHALL be combinational: rs_data, rt_data and dbg_data reflect the addressed register in the same cycle, with no clock latency.
REQ-017 Register 0 SHALL always read as 0; writes with wr_addr == 0 SHALL be discarded.
REQ-018 When wr_en = 1 and wr_addr != 0, the register SHALL take wr_data at the rising clk edge; it is visible on the read ports after that edge.
REQ-019 When wr_en = 0, no register SHALL change.
REQ-020 Both read ports SHALL be fully independent; rs_addr == rt_addr SHALL return identical data on both.
REQ-021 wr_count SHALL increment by 1 on each committed write per REQ-018 and SHALL wrap from 0xFFFF to 0x0000.
REQ-022 A discarded write to register 0 SHALL NOT increment wr_count.
REQ-023 X or Z on wr_addr while wr_en = 1 SHALL be flagged by a simulation-only assertion; there is no RTL recovery.

Reset
REQ-024 While rst_n = 0, all registers, rs_data, rt_data, dbg_data and wr_count SHALL be 0, independent of clk.
REQ-025 A write pending at reset assertion SHALL be lost; the first write SHALL be accepted at the first rising clk edge after rst_n deasserts.

Configuration
REQ-026 With macro REG_FILE_BYPASS_EN defined, a read port whose address equals wr_addr while wr_en = 1 and wr_addr != 0 SHALL return wr_data combinationally in the same cycle (write-before-read).
REQ-027 Without REG_FILE_BYPASS_EN, read ports SHALL return the stored (pre-write) value until the clock edge; dbg_data SHALL never bypass in either build.

Structure
REQ-028 Package reg_pkg SHALL hold DATA_W, ADDR_W, NUM_REGS and the named index constants REG_ZERO = 0, REG_SP = 29 and REG_RA = 31.
REQ-029 Implementation SHALL be a single module with no sub-module; the read path may be a local function shared by the three ports.

Verification
REQ-030 Reset: hold rst_n = 0, sweep all rs_addr values -> rs_data = 0 and wr_count = 0 throughout.
REQ-031 Write/read: write 0xDEADBEEF to r8, then set rs_addr = 8 and rt_addr = 8 in the next cycle -> both ports read 0xDEADBEEF and wr_count = 1.
REQ-032 r0 guard: wr_en = 1, wr_addr = 0, wr_data = 0xFFFFFFFF -> rs_addr = 0 reads 0 and wr_count is unchanged.
REQ-033 Bypass: with r5 = 0x11 stored, drive wr_en = 1, wr_addr = 5, wr_data = 0x22 and rs_addr = 5 in the same cycle -> rs_data = 0x22 with REG_FILE_BYPASS_EN defined, 0x11 without it; 0x22 in both builds after the edge.
REQ-034 Async reset mid-run: after writing r31 = 0x1234, pulse rst_n low between clock edges -> rt_data for index 31 drops to 0 immediately and wr_count = 0.
REQ-035 Counter wrap: issue 65536 writes to r1 -> wr_count returns to 0 and r1 holds the last value written.
